// File: rtl/alsu_pkg.sv
// Shared opcode constants, LED width and invalid-operation decode for the ALSU.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package alsu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ROT   = 3'b101;

    localparam int ALSU_LED_W = 16;

    // Opcodes 110/111 are unassigned; reduction only makes sense for AND/XOR.
    function automatic logic is_invalid(input logic [2:0] opcode,
                                        input logic       red_a,
                                        input logic       red_b);
        logic bad_op;
        logic bad_red;
        bad_op  = (opcode == 3'b110) || (opcode == 3'b111);
        bad_red = (red_a || red_b) && (opcode != OP_AND) && (opcode != OP_XOR);
        return bad_op || bad_red;
    endfunction

endpackage

// File: rtl/alsu_led_blinker.sv
// Error LED pattern: all-on at an invalid op, then inverts every BLINK_DIV cycles while err holds.
// Latency: 1 cycle from set_err/clr to leds.
// Backpressure: none; set_err and clr are single-cycle events, set_err wins.
module alsu_led_blinker
    import alsu_pkg::*;
#(
    parameter int BLINK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_err,
    input  logic                  clr,
    input  logic                  err,
    output logic [ALSU_LED_W-1:0] leds
);

    localparam int            CW   = $clog2(BLINK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;

    // New error restarts the pattern lit; a good result blanks it; otherwise blink while err holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            leds <= '0;
        end else if (set_err) begin
            cnt  <= '0;
            leds <= '1;
        end else if (clr) begin
            cnt  <= '0;
            leds <= '0;
        end else if (err) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                leds <= ~leds;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alsu_param.sv
// Parametrised two-stage ALSU: input register stage, then compute into the out/err registers.
// Latency: exactly 2 cycles from inputs to out; one operation per cycle.
// Backpressure: none; valid_in=0 bubbles hold out and err, valid_out marks updated cycles.
module alsu_param
    import alsu_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int FULL_ADDER = 1,
    parameter int BLINK_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [2:0]            opcode,
    input  logic                  cin,
    input  logic                  serial_in,
    input  logic                  direction,
    input  logic                  red_op_A,
    input  logic                  red_op_B,
    input  logic                  bypass_A,
    input  logic                  bypass_B,
    output logic                  valid_out,
    output logic [2*WIDTH-1:0]    out,
    output logic [ALSU_LED_W-1:0] leds,
    output logic                  err
);

    localparam int OW = 2 * WIDTH;

    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [2:0]       op1;
    logic             cin1;
    logic             sin1;
    logic             dir1;
    logic             ra1;
    logic             rb1;
    logic             ba1;
    logic             bb1;

    logic [OW-1:0]    res;
    logic             inv;
    logic             red_bit;
    logic             cin_eff;
    logic             set_err;
    logic             clr;

    // Stage 1: capture every input unconditionally; v1 qualifies the captured set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            op1  <= '0;
            cin1 <= 1'b0;
            sin1 <= 1'b0;
            dir1 <= 1'b0;
            ra1  <= 1'b0;
            rb1  <= 1'b0;
            ba1  <= 1'b0;
            bb1  <= 1'b0;
        end else begin
            v1   <= valid_in;
            a1   <= A;
            b1   <= B;
            op1  <= opcode;
            cin1 <= cin;
            sin1 <= serial_in;
            dir1 <= direction;
            ra1  <= red_op_A;
            rb1  <= red_op_B;
            ba1  <= bypass_A;
            bb1  <= bypass_B;
        end
    end

    // Stage 2 result in priority order: bypass A, bypass B, invalid, reduction, opcode.
    always_comb begin
        res     = '0;
        cin_eff = (FULL_ADDER != 0) ? cin1 : 1'b0;
        inv     = is_invalid(op1, ra1, rb1) && !ba1 && !bb1;
        // A wins over B; reduction is only reached for AND/XOR.
        if (ra1) begin
            red_bit = (op1 == OP_AND) ? (&a1) : (^a1);
        end else begin
            red_bit = (op1 == OP_AND) ? (&b1) : (^b1);
        end
        if (ba1) begin
            res = OW'(a1);
        end else if (bb1) begin
            res = OW'(b1);
        end else if (inv) begin
            res = '0;
        end else if (ra1 || rb1) begin
            res = OW'(red_bit);
        end else begin
            case (op1)
                OP_AND:   res = OW'(a1 & b1);
                OP_XOR:   res = OW'(a1 ^ b1);
                OP_ADD:   res = OW'(a1) + OW'(b1) + OW'(cin_eff);
                OP_MULT:  res = OW'(a1) * OW'(b1);
                // Shift and rotate work on the live out register so back-to-back ops chain.
                OP_SHIFT: res = dir1 ? {out[OW-2:0], sin1} : {sin1, out[OW-1:1]};
                OP_ROT:   res = dir1 ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
                default:  res = '0;
            endcase
        end
        set_err = v1 && inv;
        clr     = v1 && !inv;
    end

    // Stage 2 registers: out/err only move on a qualified operation; valid_out tracks v1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            err       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                out <= res;
                err <= inv;
            end
        end
    end

    alsu_led_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clk     (clk),
        .rst     (rst),
        .set_err (set_err),
        .clr     (clr),
        .err     (err),
        .leds    (leds)
    );

endmodule

// File: tb/tb_alsu_param.sv
// Self-checking bench: two ALSU instances (3-bit/blink 1 and 8-bit/blink 4) against a reference model.
// Latency: model applies each op two clock edges after it is driven.
// Backpressure: n/a.
module tb_alsu_param;

    typedef struct packed {
        logic       v;
        logic [2:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin, sin, dir, ra, rb, ba, bb;
    } op_t;

    typedef struct packed {
        logic [15:0] out;
        logic        err;
        logic [15:0] leds;
        logic        vout;
        logic [31:0] since;
    } st_t;

    localparam int F_CIN = 1, F_SIN = 2, F_DIR = 4, F_RA = 8, F_RB = 16, F_BA = 32, F_BB = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    op_t  i3  = '0;
    op_t  i8  = '0;

    logic        vout3, err3, vout8, err8;
    logic [5:0]  out3;
    logic [15:0] out8;
    logic [15:0] leds3, leds8;

    st_t s3 = '0, s8 = '0;
    op_t p3 = '0, p8 = '0;
    op_t nop = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alsu_param #(.WIDTH(3), .FULL_ADDER(1), .BLINK_DIV(1)) dut3 (
        .clk(clk), .rst(rst), .valid_in(i3.v), .A(i3.a[2:0]), .B(i3.b[2:0]),
        .opcode(i3.opc), .cin(i3.cin), .serial_in(i3.sin), .direction(i3.dir),
        .red_op_A(i3.ra), .red_op_B(i3.rb), .bypass_A(i3.ba), .bypass_B(i3.bb),
        .valid_out(vout3), .out(out3), .leds(leds3), .err(err3)
    );

    alsu_param #(.WIDTH(8), .FULL_ADDER(1), .BLINK_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .valid_in(i8.v), .A(i8.a), .B(i8.b),
        .opcode(i8.opc), .cin(i8.cin), .serial_in(i8.sin), .direction(i8.dir),
        .red_op_A(i8.ra), .red_op_B(i8.rb), .bypass_A(i8.ba), .bypass_B(i8.bb),
        .valid_out(vout8), .out(out8), .leds(leds8), .err(err8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(input int opc, input int a, input int b, input int flags);
        op_t o;
        o     = '0;
        o.v   = 1'b1;
        o.opc = 3'(opc);
        o.a   = 8'(a);
        o.b   = 8'(b);
        o.cin = (flags & F_CIN) != 0;
        o.sin = (flags & F_SIN) != 0;
        o.dir = (flags & F_DIR) != 0;
        o.ra  = (flags & F_RA) != 0;
        o.rb  = (flags & F_RB) != 0;
        o.ba  = (flags & F_BA) != 0;
        o.bb  = (flags & F_BB) != 0;
        return o;
    endfunction

    // Reference: what the operation means, written with plain integer arithmetic.
    function automatic st_t step(input st_t s, input op_t p, input int w, input int bd);
        st_t             n;
        longint unsigned a, b, o, m, am, r, x;
        int              ow;
        logic            inv;
        n    = s;
        ow   = 2 * w;
        m    = (64'd1 << ow) - 1;
        am   = (64'd1 << w) - 1;
        a    = 64'(p.a) & am;
        b    = 64'(p.b) & am;
        o    = 64'(s.out);
        r    = 0;
        inv  = (p.opc >= 3'd6) || ((p.ra || p.rb) && (p.opc > 3'd1));
        n.vout = p.v;
        if (p.v) begin
            if (p.ba) r = a;
            else if (p.bb) r = b;
            else if (inv) r = 0;
            else if (p.ra || p.rb) begin
                x = p.ra ? a : b;
                if (p.opc == 3'd0) r = (x == am) ? 1 : 0;
                else r = 64'($countones(x) % 2);
            end else begin
                case (p.opc)
                    3'd0: r = a & b;
                    3'd1: r = a ^ b;
                    3'd2: r = a + b + (p.cin ? 1 : 0);
                    3'd3: r = a * b;
                    3'd4: r = p.dir ? (((o << 1) | 64'(p.sin)) & m) : ((o >> 1) | (64'(p.sin) << (ow - 1)));
                    default: r = p.dir ? (((o << 1) | (o >> (ow - 1))) & m) : ((o >> 1) | ((o & 1) << (ow - 1)));
                endcase
            end
            n.out = 16'(r & m);
            if (inv && !p.ba && !p.bb) begin
                n.err = 1'b1; n.leds = 16'hFFFF; n.since = 0;
            end else begin
                n.err = 1'b0; n.leds = 16'h0000;
            end
        end else if (s.err) begin
            n.since = s.since + 1;
            n.leds  = (((n.since / bd) % 2) != 0) ? 16'h0000 : 16'hFFFF;
        end
        return n;
    endfunction

    task automatic cyc(input op_t n3, input op_t n8);
        i3 = n3;
        i8 = n8;
        @(posedge clk);
        s3 = step(s3, p3, 3, 1);
        s8 = step(s8, p8, 8, 4);
        p3 = n3;
        p8 = n8;
        @(negedge clk);
        check("out3", 64'(out3), 64'(s3.out));
        check("err3", 64'(err3), 64'(s3.err));
        check("leds3", 64'(leds3), 64'(s3.leds));
        check("vout3", 64'(vout3), 64'(s3.vout));
        check("out8", 64'(out8), 64'(s8.out));
        check("err8", 64'(err8), 64'(s8.err));
        check("leds8", 64'(leds8), 64'(s8.leds));
        check("vout8", 64'(vout8), 64'(s8.vout));
    endtask

    // Asserts reset mid-cycle and expects every output cleared before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        i3 = nop;
        i8 = nop;
        #1;
        check("rst_out3", 64'(out3), 64'd0);
        check("rst_err3", 64'(err3), 64'd0);
        check("rst_leds3", 64'(leds3), 64'd0);
        check("rst_vout3", 64'(vout3), 64'd0);
        check("rst_out8", 64'(out8), 64'd0);
        check("rst_err8", 64'(err8), 64'd0);
        check("rst_leds8", 64'(leds8), 64'd0);
        check("rst_vout8", 64'(vout8), 64'd0);
        s3 = '0; s8 = '0; p3 = '0; p8 = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic op_t rnd_op();
        op_t o;
        int  f;
        f = 0;
        if ($urandom_range(0, 1) == 1) f |= F_CIN;
        if ($urandom_range(0, 1) == 1) f |= F_SIN;
        if ($urandom_range(0, 1) == 1) f |= F_DIR;
        if ($urandom_range(0, 7) == 0) f |= F_RA;
        if ($urandom_range(0, 7) == 0) f |= F_RB;
        if ($urandom_range(0, 9) == 0) f |= F_BA;
        if ($urandom_range(0, 9) == 0) f |= F_BB;
        o = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), f);
        if ($urandom_range(0, 4) == 0) o.v = 1'b0;
        return o;
    endfunction

    initial begin
        #3;
        check("init_out3", 64'(out3), 64'd0);
        check("init_leds8", 64'(leds8), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic ops on 3-bit; 8-bit MULT/ADD/invalid alongside.
        cyc(mk(0, 5, 2, 0), mk(3, 255, 255, 0));
        cyc(mk(1, 5, 2, 0), mk(2, 255, 255, F_CIN));
        check("p1_and", 64'(out3), 64'd0);
        check("p1_and_vout", 64'(vout3), 64'd1);
        check("p6_mult", 64'(out8), 64'd65025);
        cyc(mk(2, 5, 2, F_CIN), mk(6, 0, 0, 0));
        check("p1_xor", 64'(out3), 64'd7);
        check("p6_add", 64'(out8), 64'd511);
        cyc(mk(3, 5, 2, 0), nop);
        check("p1_add", 64'(out3), 64'd8);
        check("p6_inv_leds", 64'(leds8), 64'hFFFF);
        cyc(mk(4, 0, 0, F_DIR), nop);
        check("p1_mult", 64'(out3), 64'd10);
        cyc(mk(5, 0, 0, 0), nop);
        check("p2_shl", 64'(out3), 64'd20);
        cyc(mk(4, 0, 0, F_SIN), nop);
        check("p2_rotr", 64'(out3), 64'd10);
        check("p6_leds_hold", 64'(leds8), 64'hFFFF);
        cyc(mk(6, 0, 0, 0), nop);
        check("p2_shr", 64'(out3), 64'd37);
        check("p6_leds_toggle", 64'(leds8), 64'h0000);
        cyc(nop, nop);
        check("p3_inv_out", 64'(out3), 64'd0);
        check("p3_inv_err", 64'(err3), 64'd1);
        check("p3_leds0", 64'(leds3), 64'hFFFF);
        cyc(nop, nop);
        check("p3_leds1", 64'(leds3), 64'h0000);
        cyc(mk(0, 5, 2, 0), nop);
        check("p3_leds2", 64'(leds3), 64'hFFFF);
        cyc(mk(2, 5, 2, F_RB), nop);
        check("p3_clr_err", 64'(err3), 64'd0);
        check("p3_clr_leds", 64'(leds3), 64'h0000);
        cyc(mk(1, 5, 3, F_RA | F_RB), nop);
        check("p4_redb_inv", 64'(err3), 64'd1);
        cyc(mk(7, 5, 3, F_BA), nop);
        check("p4_red_xor", 64'(out3), 64'd0);
        check("p4_red_err", 64'(err3), 64'd0);
        cyc(nop, nop);
        check("p4_byp_out", 64'(out3), 64'd5);
        check("p4_byp_err", 64'(err3), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(nop, nop);
            check("p5_hold_out", 64'(out3), 64'd5);
            check("p5_hold_vout", 64'(vout3), 64'd0);
        end
        cyc(mk(6, 0, 0, 0), mk(7, 0, 0, 0));
        cyc(nop, nop);
        cyc(nop, nop);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            else cyc(rnd_op(), rnd_op());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
